// File: rtl/fir_out_pkg.sv
// Shared constants, state type and sizing helper for the FIR output decimator.
package fir_out_pkg;

    localparam int IW_DEF     = 31;
    localparam int DW_DEF     = 16;
    localparam int SHIFT_DEF  = 12;
    localparam int DECIM_DEF  = 4;
    localparam int WARMUP_DEF = 5;
    localparam int DEPTH_DEF  = 8;

    typedef enum logic {WARM, RUN} fir_out_state_t;

    // One extra bit so a full FIFO (level == DEPTH) is distinguishable from empty.
    function automatic int levelWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// First-word-fall-through sample FIFO with occupancy count and sticky overflow flag.
module fir_out_fifo
    import fir_out_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_push,
    input  logic [DW-1:0]                  i_pushData,
    input  logic                           i_ready,
    input  logic                           i_clearOvf,
    output logic [DW-1:0]                  o_data,
    output logic                           o_valid,
    output logic [levelWidth(DEPTH)-1:0]   o_level,
    output logic                           o_overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = levelWidth(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [LW-1:0] r_level;
    logic          r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_write;
    logic w_drop;

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LW'(DEPTH));
    assign w_pop   = !w_empty && i_ready;
    assign w_write = i_push && (!w_full || w_pop);
    assign w_drop  = i_push && w_full && !w_pop;

    always_ff @(posedge i_clk) begin
        if (w_write) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_write) begin
                r_wrPtr <= (r_wrPtr == AW'(DEPTH - 1)) ? '0 : r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= (r_rdPtr == AW'(DEPTH - 1)) ? '0 : r_rdPtr + AW'(1);
            end
            r_level <= r_level + LW'(w_write) - LW'(w_pop);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_clearOvf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign o_valid    = !w_empty;
    assign o_data     = w_empty ? '0 : r_mem[r_rdPtr];
    assign o_level    = r_level;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/fir_out_decim.sv
// FIR output stage: warm-up discard, decimation, round/scale and FIFO buffering.
// Define FIROUT_SATURATE_EN to clamp scaled samples instead of wrapping them.
module fir_out_decim
    import fir_out_pkg::*;
#(
    parameter int IW     = IW_DEF,
    parameter int DW     = DW_DEF,
    parameter int SHIFT  = SHIFT_DEF,
    parameter int DECIM  = DECIM_DEF,
    parameter int WARMUP = WARMUP_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_ce,
    input  logic [IW-1:0]                  i_result,
    output logic [DW-1:0]                  o_data,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [levelWidth(DEPTH)-1:0]   o_level,
    output logic                           o_overflow,
    input  logic                           i_clear_ovf
);

    localparam int WCW = $clog2(WARMUP + 1);
    localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic signed [IW:0] HALF = {{(IW + 1 - SHIFT){1'b0}}, 1'b1, {(SHIFT - 1){1'b0}}};

    fir_out_state_t r_state;
    fir_out_state_t w_nextState;
    logic           w_keep;
    logic [WCW-1:0] r_warmCnt;
    logic [DCW-1:0] r_decimCnt;
    logic           r_stagePush;
    logic [DW-1:0]  r_stageData;

    logic signed [IW:0] w_extended;
    logic signed [IW:0] w_rounded;
    logic signed [IW:0] w_shifted;
    logic [DW-1:0]      w_scaled;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= WARM;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_keep      = 1'b0;
        case (r_state)
            WARM: begin
                if (i_ce && (r_warmCnt == WCW'(WARMUP - 1))) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                w_keep = i_ce && (r_decimCnt == '0);
            end
            default: w_nextState = WARM;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_warmCnt  <= '0;
            r_decimCnt <= '0;
        end else if (i_ce) begin
            if (r_state == WARM) begin
                r_warmCnt <= r_warmCnt + WCW'(1);
            end else begin
                r_decimCnt <= (r_decimCnt == DCW'(DECIM - 1)) ? '0 : r_decimCnt + DCW'(1);
            end
        end
    end

    // The extra sign bit keeps the rounding add from overflowing at full-scale input.
    assign w_extended = {i_result[IW-1], i_result};
    assign w_rounded  = w_extended + HALF;
    assign w_shifted  = w_rounded >>> SHIFT;

`ifdef FIROUT_SATURATE_EN
    localparam logic signed [IW:0] SAT_MAX = {{(IW - DW + 2){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [IW:0] SAT_MIN = {{(IW - DW + 2){1'b1}}, {(DW - 1){1'b0}}};

    always_comb begin
        w_scaled = w_shifted[DW-1:0];
        if (w_shifted > SAT_MAX) begin
            w_scaled = {1'b0, {(DW - 1){1'b1}}};
        end else if (w_shifted < SAT_MIN) begin
            w_scaled = {1'b1, {(DW - 1){1'b0}}};
        end
    end
`else
    logic w_unusedHigh;
    assign w_scaled     = w_shifted[DW-1:0];
    assign w_unusedHigh = ^w_shifted[IW:DW];
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stagePush <= 1'b0;
            r_stageData <= '0;
        end else begin
            r_stagePush <= w_keep;
            if (w_keep) begin
                r_stageData <= w_scaled;
            end
        end
    end

    fir_out_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_push     (r_stagePush),
        .i_pushData (r_stageData),
        .i_ready    (i_ready),
        .i_clearOvf (i_clear_ovf),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_level    (o_level),
        .o_overflow (o_overflow)
    );

endmodule

// File: tb/tb_fir_out_decim.sv
// Self-checking bench for fir_out_decim against a queue-based sample model.
module tb_fir_out_decim;

    localparam int IW     = 31;
    localparam int DW     = 16;
    localparam int DEPTH  = 8;
    localparam int WARMUP = 5;
    localparam int DECIM  = 4;
    localparam int LW     = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ce = 1'b0;
    logic [IW-1:0] result = '0;
    logic [DW-1:0] data;
    logic          valid;
    logic          ready = 1'b0;
    logic [LW-1:0] level;
    logic          overflow;
    logic          clearOvf = 1'b0;

    int total = 0;
    int bad = 0;

    // Model state: samples seen since reset, one-cycle stage, FIFO contents, sticky flag.
    int            ceCount = 0;
    bit            pendValid = 1'b0;
    logic [DW-1:0] pendVal = '0;
    logic [DW-1:0] expQ[$];
    bit            mOvf = 1'b0;

    fir_out_decim dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_ce        (ce),
        .i_result    (result),
        .o_data      (data),
        .o_valid     (valid),
        .i_ready     (ready),
        .o_level     (level),
        .o_overflow  (overflow),
        .i_clear_ovf (clearOvf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [DW-1:0] scaleModel(input longint x);
        longint n;
        longint q;
        n = x + 2048;
        q = n / 4096;
        if ((n % 4096 != 0) && (n < 0)) q = q - 1;
`ifdef FIROUT_SATURATE_EN
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
`endif
        return q[DW-1:0];
    endfunction

    function automatic bit isKept(input int idx);
        return (idx >= WARMUP) && (((idx - WARMUP) % DECIM) == 0);
    endfunction

    function automatic logic [DW-1:0] expData();
        return (expQ.size() > 0) ? expQ[0] : '0;
    endfunction

    // Advance the model by the cycle about to end, then move to just after the next edge.
    task automatic tick();
        bit            popNow;
        bit            pushNow;
        bit            dropNow;
        logic [DW-1:0] pushVal;
        popNow    = ready && (expQ.size() > 0);
        pushNow   = pendValid;
        pushVal   = pendVal;
        pendValid = ce && isKept(ceCount);
        pendVal   = scaleModel(longint'($signed(result)));
        if (ce) ceCount++;
        if (popNow) void'(expQ.pop_front());
        dropNow = 1'b0;
        if (pushNow) begin
            if (expQ.size() < DEPTH) expQ.push_back(pushVal);
            else dropNow = 1'b1;
        end
        if (dropNow) mOvf = 1'b1;
        else if (clearOvf) mOvf = 1'b0;
        if (reset) begin
            expQ.delete();
            ceCount   = 0;
            pendValid = 1'b0;
            mOvf      = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic sendSample(input logic [IW-1:0] v);
        ce = 1'b1;
        result = v;
        tick();
        ce = 1'b0;
        result = '0;
    endtask

    task automatic alignToKept();
        while (!isKept(ceCount)) begin
            sendSample('0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid got=%0b want=0", valid); end
        total++; if (level !== '0) begin bad++; $display("[TB] FAIL rst_level got=%0d want=0", level); end
        total++; if (data !== '0) begin bad++; $display("[TB] FAIL rst_data got=%h want=0", data); end
        total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL rst_ovf got=%0b want=0", overflow); end
    endtask

    task automatic test_warmup();
        ready = 1'b0;
        for (int i = 0; i < WARMUP; i++) sendSample(IW'(32'h1000));
        tick();
        total++; if (level !== '0) begin bad++; $display("[TB] FAIL warm_level got=%0d want=0", level); end
        sendSample(IW'(32'h1000));
        total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL warm_early got=%0b want=0", valid); end
        tick();
        total++; if (valid !== 1'b1) begin bad++; $display("[TB] FAIL warm_valid got=%0b want=1", valid); end
        total++; if (data !== 16'd1) begin bad++; $display("[TB] FAIL warm_data got=%h want=0001", data); end
        total++; if (level !== 4'd1) begin bad++; $display("[TB] FAIL warm_level1 got=%0d want=1", level); end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL warm_pop got=%0b want=0", valid); end
    endtask

    task automatic test_rounding();
        int            vals[4];
        logic [DW-1:0] want[4];
        vals = '{32'h800, 32'h7FF, -2048, -2049};
        want = '{16'h0001, 16'h0000, 16'h0000, 16'hFFFF};
        for (int i = 0; i < 4; i++) begin
            alignToKept();
            sendSample(IW'(vals[i]));
            tick();
            total++; if (valid !== 1'b1) begin bad++; $display("[TB] FAIL round_valid[%0d] got=%0b want=1", i, valid); end
            total++; if (data !== want[i]) begin bad++; $display("[TB] FAIL round_data[%0d] got=%h want=%h", i, data, want[i]); end
            ready = 1'b1;
            tick();
            ready = 1'b0;
        end
    endtask

    task automatic test_scale_limits();
        int            vals[2];
        logic [DW-1:0] want[2];
        vals = '{32'h0800_0000, -134221824};
`ifdef FIROUT_SATURATE_EN
        want = '{16'h7FFF, 16'h8000};
`else
        want = '{16'h8000, 16'h7FFF};
`endif
        for (int i = 0; i < 2; i++) begin
            alignToKept();
            sendSample(IW'(vals[i]));
            tick();
            total++; if (data !== want[i]) begin bad++; $display("[TB] FAIL limit_data[%0d] got=%h want=%h", i, data, want[i]); end
            ready = 1'b1;
            tick();
            ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        bit            wantValid;
        logic [DW-1:0] wantData;
        ready = 1'b1;
        alignToKept();
        for (int c = 0; c < 14; c++) begin
            ce = (c < 12);
            result = IW'(c * 4096);
            wantValid = (c >= 2) && (((c - 2) % DECIM) == 0);
            wantData = wantValid ? DW'(c - 2) : '0;
            total++; if (valid !== wantValid) begin bad++; $display("[TB] FAIL b2b_valid[%0d] got=%0b want=%0b", c, valid, wantValid); end
            total++; if (data !== wantData) begin bad++; $display("[TB] FAIL b2b_data[%0d] got=%h want=%h", c, data, wantData); end
            tick();
        end
        ce = 1'b0;
        result = '0;
        ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [DW-1:0] vals[9];
        logic [IW-1:0] v;
        ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            alignToKept();
            if (i == 8) begin
                total++; if (level !== 4'd8) begin bad++; $display("[TB] FAIL ovf_full got=%0d want=8", level); end
                total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL ovf_early got=%0b want=0", overflow); end
            end
            v = IW'($urandom);
            vals[i] = scaleModel(longint'($signed(v)));
            sendSample(v);
        end
        tick();
        total++; if (level !== 4'd8) begin bad++; $display("[TB] FAIL ovf_level got=%0d want=8", level); end
        total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_set got=%0b want=1", overflow); end
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++; if (data !== vals[i]) begin bad++; $display("[TB] FAIL ovf_drain[%0d] got=%h want=%h", i, data, vals[i]); end
            tick();
        end
        ready = 1'b0;
        total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL ovf_empty got=%0b want=0", valid); end
        total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_sticky got=%0b want=1", overflow); end
        clearOvf = 1'b1;
        tick();
        clearOvf = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL ovf_clear got=%0b want=0", overflow); end
    endtask

    task automatic test_full_pushpop();
        logic [DW-1:0] vals[9];
        logic [IW-1:0] v;
        ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            alignToKept();
            v = IW'($urandom);
            vals[i] = scaleModel(longint'($signed(v)));
            sendSample(v);
        end
        ready = 1'b1;
        tick();
        total++; if (level !== 4'd8) begin bad++; $display("[TB] FAIL pp_level got=%0d want=8", level); end
        total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL pp_ovf got=%0b want=0", overflow); end
        for (int i = 1; i < 9; i++) begin
            total++; if (data !== vals[i]) begin bad++; $display("[TB] FAIL pp_drain[%0d] got=%h want=%h", i, data, vals[i]); end
            tick();
        end
        ready = 1'b0;
        total++; if (level !== '0) begin bad++; $display("[TB] FAIL pp_empty got=%0d want=0", level); end
    endtask

    task automatic test_reset_mid();
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            alignToKept();
            sendSample(IW'($urandom));
        end
        tick();
        total++; if (level !== 4'd3) begin bad++; $display("[TB] FAIL mid_level3 got=%0d want=3", level); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_valid got=%0b want=0", valid); end
        total++; if (level !== '0) begin bad++; $display("[TB] FAIL mid_level got=%0d want=0", level); end
        total++; if (data !== '0) begin bad++; $display("[TB] FAIL mid_data got=%h want=0", data); end
        total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL mid_ovf got=%0b want=0", overflow); end
        for (int i = 0; i < WARMUP; i++) sendSample(IW'(32'h1000));
        sendSample(IW'(32'h2000));
        total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_discard got=%0b want=0", valid); end
        tick();
        total++; if (valid !== 1'b1) begin bad++; $display("[TB] FAIL mid_kept got=%0b want=1", valid); end
        total++; if (data !== 16'd2) begin bad++; $display("[TB] FAIL mid_data6 got=%h want=0002", data); end
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            ce = ($urandom_range(0, 9) < 7);
            if (i % 2 == 0) result = IW'($urandom);
            else result = IW'(int'($urandom_range(0, 400000)) - 200000);
            ready = ($urandom_range(0, 9) < ((i < 200) ? 1 : 6));
            clearOvf = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 149) == 0);
            total++; if (valid !== (expQ.size() > 0)) begin bad++; $display("[TB] FAIL rnd_valid[%0d] got=%0b want=%0b", i, valid, expQ.size() > 0); end
            total++; if (level !== LW'(expQ.size())) begin bad++; $display("[TB] FAIL rnd_level[%0d] got=%0d want=%0d", i, level, expQ.size()); end
            total++; if (data !== expData()) begin bad++; $display("[TB] FAIL rnd_data[%0d] got=%h want=%h", i, data, expData()); end
            total++; if (overflow !== mOvf) begin bad++; $display("[TB] FAIL rnd_ovf[%0d] got=%0b want=%0b", i, overflow, mOvf); end
            tick();
        end
        ce = 1'b0;
        ready = 1'b0;
        clearOvf = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_rounding();
        test_scale_limits();
        test_back_to_back();
        test_overflow();
        test_full_pushpop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
